// File: rtl/flash_playback_sequencer_pkg.sv
// Shared types and constants for the flash playback sequencer: FSM encoding,
// audio/flash data widths and the default last word address of the sample flash.
package flash_playback_sequencer_pkg;

    localparam int          SAMPLE_W         = 16;
    localparam int          FLASH_DW         = 32;
    localparam int unsigned DEFAULT_END_ADDR = 32'h0007_FFFF;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_REQ       = 3'd1,
        ST_WAIT_DATA = 3'd2,
        ST_HALF0     = 3'd3,
        ST_HALF1     = 3'd4,
        ST_ADVANCE   = 3'd5
    } state_e;

    // Picks one 16-bit half of a flash word; upper=1 selects bits [31:16].
    function automatic logic [SAMPLE_W-1:0] select_half(input logic [FLASH_DW-1:0] word,
                                                        input logic                upper);
        return upper ? word[FLASH_DW-1:SAMPLE_W] : word[SAMPLE_W-1:0];
    endfunction

endpackage

// File: rtl/flash_playback_sequencer_if.sv
// Avalon-MM read-only link between the playback sequencer (master) and the flash controller (slave).
interface flash_playback_sequencer_if #(
    parameter int ADDR_W = 24
);
    import flash_playback_sequencer_pkg::*;

    logic                read;
    logic [ADDR_W-1:0]   address;
    logic                waitrequest;
    logic [FLASH_DW-1:0] readdata;
    logic                readdatavalid;

    modport master (
        output read,
        output address,
        input  waitrequest,
        input  readdata,
        input  readdatavalid
    );

    modport slave (
        input  read,
        input  address,
        output waitrequest,
        output readdata,
        output readdatavalid
    );

endinterface

// File: rtl/flash_playback_sequencer_addr_counter.sv
// Playback word address: up/down counter wrapping between 0 and END_ADDR, with a
// synchronous clear that overrides stepping.
module flash_playback_sequencer_addr_counter #(
    parameter int                ADDR_W   = 24,
    parameter logic [ADDR_W-1:0] END_ADDR = '1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_i,
    input  logic              step_i,
    input  logic              dir_bwd_i,
    output logic [ADDR_W-1:0] adr_o
);

    logic [ADDR_W-1:0] adr_q, adr_d;

    always_comb begin
        // NOTE: the hold value is assigned first so every path drives adr_d; without it this would infer a latch.
        adr_d = adr_q;
        if (clr_i) begin
            adr_d = '0;
        end else if (step_i) begin
            if (dir_bwd_i) begin
                adr_d = (adr_q == '0) ? END_ADDR : adr_q - ADDR_W'(1);
            end else begin
                adr_d = (adr_q == END_ADDR) ? '0 : adr_q + ADDR_W'(1);
            end
        end
    end

    // NOTE: registers are updated with non-blocking assignments so all flops sample pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            adr_q <= '0;
        end else begin
            adr_q <= adr_d;
        end
    end

    assign adr_o = adr_q;

endmodule

// File: rtl/flash_playback_sequencer.sv
// Flash playback sequencer: fetches 32-bit words from sample flash over Avalon-MM and plays
// each out as two 16-bit audio samples, forward or backward, one per sample strobe.
module flash_playback_sequencer
    import flash_playback_sequencer_pkg::*;
#(
    parameter int                ADDR_W   = 24,
    parameter logic [ADDR_W-1:0] END_ADDR = ADDR_W'(DEFAULT_END_ADDR),
    parameter int                UCNT_W   = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       bF,
    input  logic                       fF,
    input  logic                       pause,
    input  logic                       rst,
    input  logic                       sample_strobe,
    flash_playback_sequencer_if.master flash,
    output logic [ADDR_W-1:0]          adr,
    output logic [SAMPLE_W-1:0]        audio_sample,
    output logic                       sample_valid,
    output logic [UCNT_W-1:0]          underrun_cnt
);

    state_e              state_q, state_d;
    logic [FLASH_DW-1:0] word_q, word_d;
    logic [SAMPLE_W-1:0] sample_q, sample_d;
    logic [UCNT_W-1:0]   ucnt_q, ucnt_d;
    logic                dir_bwd_q, dir_bwd_d;
    logic                drop_q, drop_d;
    logic                valid_q, valid_d;
    logic                adr_clr, adr_step, missed, read_req;
    logic                dir_bwd_live;

    // Both flags set plays forward.
    assign dir_bwd_live = bF & ~fF;

    flash_playback_sequencer_addr_counter #(
        .ADDR_W   (ADDR_W),
        .END_ADDR (END_ADDR)
    ) u_addr_counter (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_i     (adr_clr),
        .step_i    (adr_step),
        .dir_bwd_i (dir_bwd_live),
        .adr_o     (adr)
    );

    always_comb begin
        state_d   = state_q;
        word_d    = word_q;
        dir_bwd_d = dir_bwd_q;
        drop_d    = drop_q;
        sample_d  = sample_q;
        valid_d   = 1'b0;
        ucnt_d    = ucnt_q;
        adr_clr   = 1'b0;
        adr_step  = 1'b0;
        missed    = 1'b0;
        read_req  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (rst) begin
                    adr_clr = 1'b1;
                end else if (!pause) begin
                    missed  = sample_strobe;
                    state_d = ST_REQ;
                end
            end
            // An accepted read always runs to readdatavalid; a restart seen meanwhile only marks it for discard.
            ST_REQ: begin
                read_req = 1'b1;
                missed   = sample_strobe & ~rst;
                if (rst) drop_d = 1'b1;
                if (!flash.waitrequest) state_d = ST_WAIT_DATA;
            end
            ST_WAIT_DATA: begin
                missed = sample_strobe & ~rst;
                if (rst) drop_d = 1'b1;
                if (flash.readdatavalid) begin
                    drop_d = 1'b0;
                    if (rst || drop_q) begin
                        adr_clr = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        word_d    = flash.readdata;
                        dir_bwd_d = dir_bwd_live;
                        state_d   = ST_HALF0;
                    end
                end
            end
            ST_HALF0, ST_HALF1: begin
                if (rst) begin
                    adr_clr = 1'b1;
                    state_d = ST_IDLE;
                end else if (sample_strobe) begin
                    sample_d = select_half(word_q, (state_q == ST_HALF0) ? dir_bwd_q : ~dir_bwd_q);
                    valid_d  = 1'b1;
                    state_d  = (state_q == ST_HALF0) ? ST_HALF1 : ST_ADVANCE;
                end
            end
            ST_ADVANCE: begin
                missed = sample_strobe & ~rst;
                if (rst) begin
                    adr_clr = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    adr_step = 1'b1;
                    state_d  = pause ? ST_IDLE : ST_REQ;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (missed && (ucnt_q != '1)) ucnt_d = ucnt_q + UCNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            // NOTE: the word holder is a single register, not a RAM, so it is reset with the rest of the state.
            word_q    <= '0;
            dir_bwd_q <= 1'b0;
            drop_q    <= 1'b0;
            sample_q  <= '0;
            valid_q   <= 1'b0;
            ucnt_q    <= '0;
        end else begin
            state_q   <= state_d;
            word_q    <= word_d;
            dir_bwd_q <= dir_bwd_d;
            drop_q    <= drop_d;
            sample_q  <= sample_d;
            valid_q   <= valid_d;
            ucnt_q    <= ucnt_d;
        end
    end

    assign flash.read    = read_req;
    assign flash.address = adr;
    assign audio_sample  = sample_q;
    assign sample_valid  = valid_q;
    assign underrun_cnt  = ucnt_q;

endmodule

// File: tb/tb_flash_playback_sequencer.sv
// Directed bench for the flash playback sequencer with a behavioural Avalon flash model.
module tb_flash_playback_sequencer;
    import flash_playback_sequencer_pkg::*;

    localparam int                ADDR_W   = 24;
    localparam logic [ADDR_W-1:0] END_ADDR = 24'h103;

    typedef struct packed {
        logic [15:0]       smp;
        logic [ADDR_W-1:0] adr;
    } sample_t;

    logic              clk = 1'b0;
    logic              rst_n, bF, fF, pause, rst, sample_strobe;
    logic [ADDR_W-1:0] adr;
    logic [15:0]       audio_sample;
    logic              sample_valid;
    logic [7:0]        underrun_cnt;

    flash_playback_sequencer_if #(.ADDR_W(ADDR_W)) fl ();

    flash_playback_sequencer #(
        .ADDR_W   (ADDR_W),
        .END_ADDR (END_ADDR),
        .UCNT_W   (8)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bF            (bF),
        .fF            (fF),
        .pause         (pause),
        .rst           (rst),
        .sample_strobe (sample_strobe),
        .flash         (fl),
        .adr           (adr),
        .audio_sample  (audio_sample),
        .sample_valid  (sample_valid),
        .underrun_cnt  (underrun_cnt)
    );

    always #5 clk = ~clk;

    int        n_checks = 0;
    int        n_fail   = 0;
    sample_t   got_q[$];

    // Flash model knobs and statistics
    int          wait_cycles = 0;
    int          latency     = 2;
    int          stall       = 0;
    int          lat         = 0;
    int          stall_total = 0;
    int          addr_err    = 0;
    int          accepts     = 0;
    int          rdv_count   = 0;
    logic [23:0] stall_addr  = '0;
    logic [23:0] req_addr    = '0;

    // Strobe generator knobs
    int strobe_period = 0;
    int strobe_phase  = 0;
    bit strobe_req    = 1'b0;

    function automatic logic [31:0] word_at(input logic [23:0] a);
        if (a == 24'h0)          return 32'h2222_1111;
        else if (a == 24'h1)     return 32'h4444_3333;
        else if (a == 24'h2)     return 32'h6666_5555;
        else if (a == END_ADDR)  return 32'hBBBB_AAAA;
        else                     return {8'hC0, a[7:0], 8'hD0, a[7:0]};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic pulse_strobe();
        strobe_req = 1'b1;
        tick(1);
    endtask

    task automatic check_sample(input string tag, input int idx,
                                input logic [15:0] exp_smp, input logic [23:0] exp_adr);
        sample_t s;
        s = '1;
        if (idx < got_q.size()) s = got_q[idx];
        check({tag, "_smp"}, 32'(s.smp), 32'(exp_smp));
        check({tag, "_adr"}, 32'(s.adr), 32'(exp_adr));
    endtask

    task automatic wait_samples(input string tag, input int n, input int budget);
        int cyc;
        cyc = 0;
        while (got_q.size() < n && cyc < budget) begin
            tick(1);
            cyc++;
        end
        check(tag, 32'(got_q.size() >= n), 32'd1);
    endtask

    task automatic wait_rdv(input string tag, input int budget);
        int cyc;
        cyc = 0;
        while (!fl.readdatavalid && cyc < budget) begin
            tick(1);
            cyc++;
        end
        check(tag, 32'(fl.readdatavalid), 32'd1);
    endtask

    task automatic wait_read(input string tag, input int budget);
        int cyc;
        cyc = 0;
        while (!fl.read && cyc < budget) begin
            tick(1);
            cyc++;
        end
        check(tag, 32'(fl.read), 32'd1);
    endtask

    initial begin : sample_monitor
        sample_t s;
        forever begin
            @(negedge clk);
            if (rst_n && sample_valid) begin
                s.smp = audio_sample;
                s.adr = adr;
                got_q.push_back(s);
            end
        end
    end

    initial begin : strobe_gen
        bit periodic;
        sample_strobe = 1'b0;
        forever begin
            @(negedge clk);
            periodic = 1'b0;
            if (strobe_period > 0) begin
                if (strobe_phase >= strobe_period - 1) begin
                    periodic     = 1'b1;
                    strobe_phase = 0;
                end else begin
                    strobe_phase++;
                end
            end
            sample_strobe = strobe_req || periodic;
            strobe_req    = 1'b0;
        end
    end

    // Decides waitrequest/readdatavalid at each falling edge for the following rising edge.
    initial begin : flash_model
        fl.waitrequest   = 1'b0;
        fl.readdatavalid = 1'b0;
        fl.readdata      = '0;
        forever begin
            @(negedge clk);
            fl.readdatavalid = 1'b0;
            if (!rst_n) begin
                stall          = 0;
                lat            = 0;
                fl.waitrequest = 1'b0;
            end else begin
                if (lat > 0) begin
                    lat--;
                    if (lat == 0) begin
                        fl.readdatavalid = 1'b1;
                        fl.readdata      = word_at(req_addr);
                        rdv_count++;
                    end
                end
                if (fl.read) begin
                    if (stall < wait_cycles) begin
                        if (stall == 0) stall_addr = fl.address;
                        else if (fl.address != stall_addr) addr_err++;
                        fl.waitrequest = 1'b1;
                        stall++;
                        stall_total++;
                    end else begin
                        if (stall > 0 && fl.address != stall_addr) addr_err++;
                        fl.waitrequest = 1'b0;
                        stall          = 0;
                        req_addr       = fl.address;
                        lat            = latency;
                        accepts++;
                    end
                end else begin
                    fl.waitrequest = 1'b0;
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        logic [15:0] bwd_smp [9];
        logic [23:0] bwd_adr [9];
        int base, acc0, rdv0;

        bwd_smp = '{16'h2222, 16'h1111, 16'hBBBB, 16'hAAAA, 16'hC002, 16'hD002, 16'hC001, 16'hD001, 16'hC000};
        bwd_adr = '{24'h0, 24'h0, 24'h103, 24'h103, 24'h102, 24'h102, 24'h101, 24'h101, 24'h100};

        rst_n = 1'b0; bF = 1'b0; fF = 1'b0; pause = 1'b1; rst = 1'b0;
        tick(3);
        check("reset_read",   32'(fl.read), 32'd0);
        check("reset_adr",    32'(adr), 32'd0);
        check("reset_sample", 32'(audio_sample), 32'd0);
        check("reset_valid",  32'(sample_valid), 32'd0);
        check("reset_ucnt",   32'(underrun_cnt), 32'd0);
        rst_n = 1'b1;
        tick(4);
        check("paused_idle_read", 32'(fl.read), 32'd0);

        // Forward playback of words 0 and 1, then pause during ADVANCE
        fF = 1'b1; strobe_period = 8; pause = 1'b0;
        wait_samples("fwd_wait", 4, 400);
        pause = 1'b1;
        tick(10);
        check_sample("fwd0", 0, 16'h1111, 24'h0);
        check_sample("fwd1", 1, 16'h2222, 24'h0);
        check_sample("fwd2", 2, 16'h3333, 24'h1);
        check_sample("fwd3", 3, 16'h4444, 24'h1);
        check("fwd_count", 32'(got_q.size()), 32'd4);
        check("fwd_adr",   32'(adr), 32'd2);

        // Restart from IDLE, then backward playback wrapping 0 -> END_ADDR
        rst = 1'b1;
        tick(2);
        check("idle_rst_adr", 32'(adr), 32'd0);
        rst = 1'b0;
        base = got_q.size();
        fF = 1'b0; bF = 1'b1; pause = 1'b0;
        wait_samples("bwd_wait", base + 9, 1500);
        rst = 1'b1;                                // DUT is now in HALF1 of word 0x100
        tick(1);
        check("restart_adr", 32'(adr), 32'd0);
        for (int i = 0; i < 9; i++) check_sample($sformatf("bwd%0d", i), base + i, bwd_smp[i], bwd_adr[i]);
        tick(24);
        check("restart_no_valid", 32'(got_q.size()), 32'(base + 9));
        check("restart_hold_read", 32'(fl.read), 32'd0);
        check("restart_hold_adr",  32'(adr), 32'd0);
        rst = 1'b0; fF = 1'b1; bF = 1'b0;
        wait_samples("restart_wait", base + 11, 600);
        check_sample("restart_w0a", base + 9,  16'h1111, 24'h0);
        check_sample("restart_w0b", base + 10, 16'h2222, 24'h0);

        // Pause asserted in HALF0 of word 1: both halves still play, then IDLE at adr 2
        wait_rdv("pause_rdv", 100);
        tick(1);
        pause = 1'b1;
        tick(60);
        check_sample("pause_h0", base + 11, 16'h3333, 24'h1);
        check_sample("pause_h1", base + 12, 16'h4444, 24'h1);
        check("pause_count",     32'(got_q.size()), 32'(base + 13));
        check("pause_adr",       32'(adr), 32'd2);
        check("pause_idle_read", 32'(fl.read), 32'd0);

        // Five cycles of waitrequest on the word 2 read
        base = got_q.size(); acc0 = accepts; rdv0 = rdv_count; stall_total = 0; addr_err = 0;
        wait_cycles = 5; pause = 1'b0;
        wait_samples("wr_wait", base + 2, 600);
        pause = 1'b1;
        tick(20);
        check_sample("wr_h0", base,     16'h5555, 24'h2);
        check_sample("wr_h1", base + 1, 16'h6666, 24'h2);
        check("wr_stall_cycles", 32'(stall_total), 32'd5);
        check("wr_addr_stable",  32'(addr_err), 32'd0);
        check("wr_accepts",      32'(accepts - acc0), 32'd1);
        check("wr_rdv",          32'(rdv_count - rdv0), 32'd1);
        check("wr_count",        32'(got_q.size()), 32'(base + 2));
        check("wr_adr",          32'(adr), 32'd3);

        // Asynchronous reset while a read is stalled in REQ
        strobe_period = 0; wait_cycles = 100000; pause = 1'b0;
        wait_read("ar_read_seen", 20);
        #2 rst_n = 1'b0;
        #1;
        check("ar_read",   32'(fl.read), 32'd0);
        check("ar_adr",    32'(adr), 32'd0);
        check("ar_sample", 32'(audio_sample), 32'd0);
        check("ar_valid",  32'(sample_valid), 32'd0);
        check("ar_ucnt",   32'(underrun_cnt), 32'd0);
        pause = 1'b1; wait_cycles = 0; latency = 10;
        tick(3);
        rst_n = 1'b1;
        tick(2);

        // Underruns: none while paused, one per strobe while the fetch is outstanding
        repeat (3) begin
            pulse_strobe();
            tick(2);
        end
        check("ur_paused", 32'(underrun_cnt), 32'd0);
        pause = 1'b0;
        wait_read("ur_read_seen", 20);
        repeat (3) begin
            pulse_strobe();
            tick(2);
        end
        check("ur_missed3", 32'(underrun_cnt), 32'd3);
        wait_rdv("ur_rdv", 40);
        tick(1);
        base = got_q.size();
        pulse_strobe();
        wait_samples("ur_h0_wait", base + 1, 10);
        wait_cycles = 100000;
        pulse_strobe();
        wait_samples("ur_h1_wait", base + 2, 10);
        tick(5);
        check_sample("ur_h0", base,     16'h1111, 24'h0);
        check_sample("ur_h1", base + 1, 16'h2222, 24'h0);
        check("ur_halves_no_miss", 32'(underrun_cnt), 32'd3);
        check("ur_stuck_read",     32'(fl.read), 32'd1);
        check("ur_stuck_adr",      32'(adr), 32'd1);

        // 300 strobes while stuck in REQ: count climbs then saturates
        for (int i = 0; i < 300; i++) begin
            pulse_strobe();
            tick(2);
            if (i == 99) check("ur_count_103", 32'(underrun_cnt), 32'd103);
        end
        check("ur_saturated", 32'(underrun_cnt), 32'hFF);
        check("ur_sat_sample_hold", 32'(audio_sample), 32'h2222);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
